// File: rtl/glyph_row_streamer.sv
// Font ROM reader: fetches the 16 rows of one glyph and serializes them as a valid/ready pixel stream.
// Optional GLYPH_SCALE2_EN: pixel-doubled 32x32 output (each row fetched twice, each bit shown twice).
module glyph_row_streamer #(
  parameter int NUM_GLYPHS = 18,
  parameter int BLANK_CODE = 16,
  parameter int ROWS       = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [4:0]  char_code_in,
  input  logic        char_valid_in,
  output logic        char_ready_out,
  output logic [8:0]  rom_addr_out,
  input  logic [15:0] rom_data_in,
  output logic        pix_out,
  output logic        pix_valid_out,
  input  logic        pix_ready_in,
  output logic [4:0]  pix_x_out,
  output logic [4:0]  pix_y_out,
  output logic        pix_last_out,
  output logic        busy_out
);

  // state | meaning
  // IDLE  | waiting for a glyph code; rom_addr_out holds its last value
  // ADDR  | ROM samples rom_addr_out at the end of this cycle
  // LATCH | rom_data_in valid; loaded into the shift register
  // SHIFT | presenting pixels of the current row, MSB first
  typedef enum logic [1:0] {IDLE, ADDR, LATCH, SHIFT} state_t;

`ifdef GLYPH_SCALE2_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif
  localparam int         OUT_DIM  = ROWS << SCALE_SH;
  localparam logic [4:0] LAST_IDX = 5'(OUT_DIM - 1);

  state_t      state, state_nxt;
  logic [4:0]  code_q;
  logic [4:0]  row;
  logic [4:0]  col;
  logic [15:0] shreg;
  logic [4:0]  eff_code;
  logic [4:0]  addr_code;
  logic [4:0]  addr_row;
  logic [8:0]  addr_nxt;
  logic        accept;
  logic        col_end;
  logic        row_end;
  logic        shift_en;

  assign eff_code = (32'(char_code_in) < NUM_GLYPHS) ? char_code_in : 5'(BLANK_CODE);
  assign accept   = (state == IDLE) && char_valid_in;
  assign col_end  = (col == LAST_IDX);
  assign row_end  = (row == LAST_IDX);

`ifdef GLYPH_SCALE2_EN
  // Each source bit is held for two transfers; advance after the odd column.
  assign shift_en  = col[0];
  assign pix_x_out = col;
  assign pix_y_out = row;
`else
  assign shift_en  = 1'b1;
  assign pix_x_out = {1'b0, col[3:0]};
  assign pix_y_out = {1'b0, row[3:0]};
`endif

  // Address for the accepted glyph's first row, or the following output row.
  always_comb begin
    addr_code = code_q;
    addr_row  = row + 5'd1;
    if (accept) begin
      addr_code = eff_code;
      addr_row  = 5'd0;
    end
    addr_nxt = 9'(addr_code) * 9'(ROWS) + 9'(addr_row >> SCALE_SH);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ADDR;
      ADDR:  state_nxt = LATCH;
      LATCH: state_nxt = SHIFT;
      SHIFT: if (pix_ready_in && col_end) state_nxt = row_end ? IDLE : ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      code_q       <= '0;
      row          <= '0;
      col          <= '0;
      shreg        <= '0;
      rom_addr_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          code_q       <= eff_code;
          row          <= '0;
          rom_addr_out <= addr_nxt;
        end
        LATCH: begin
          shreg <= rom_data_in;
          col   <= '0;
        end
        SHIFT: if (pix_ready_in) begin
          if (shift_en) shreg <= {shreg[14:0], 1'b0};
          col <= col_end ? 5'd0 : col + 5'd1;
          if (col_end) begin
            if (row_end) begin
              row <= '0;
            end else begin
              row          <= row + 5'd1;
              rom_addr_out <= addr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_valid_out  = (state == SHIFT);
  assign pix_out        = pix_valid_out & shreg[15];
  assign pix_last_out   = pix_valid_out && col_end && row_end;
  assign busy_out       = (state != IDLE);
  assign char_ready_out = (state == IDLE);

endmodule

// File: tb/tb_glyph_row_streamer.sv
// Self-checking bench for glyph_row_streamer: bench-owned font ROM, scoreboard of expected pixels per accepted glyph.
// Honours GLYPH_SCALE2_EN the same way as the design (32x32 output when defined).
module tb_glyph_row_streamer;

`ifdef GLYPH_SCALE2_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif
  localparam int NOUT      = 16 << SC;
  localparam int GLYPH_CYC = NOUT * (NOUT + 2);

  logic        clk;
  logic        rst_n;
  logic [4:0]  char_code;
  logic        char_valid;
  logic        char_ready;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data;
  logic        pix;
  logic        pix_valid;
  logic        pix_ready;
  logic [4:0]  pix_x;
  logic [4:0]  pix_y;
  logic        pix_last;
  logic        busy;

  glyph_row_streamer dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .char_code_in   (char_code),
    .char_valid_in  (char_valid),
    .char_ready_out (char_ready),
    .rom_addr_out   (rom_addr),
    .rom_data_in    (rom_data),
    .pix_out        (pix),
    .pix_valid_out  (pix_valid),
    .pix_ready_in   (pix_ready),
    .pix_x_out      (pix_x),
    .pix_y_out      (pix_y),
    .pix_last_out   (pix_last),
    .busy_out       (busy)
  );

  typedef struct packed {
    logic [8:0] addr;
    logic [4:0] x;
    logic [4:0] y;
    logic       pix;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rom_mem [512];
  logic [15:0] rom_q;
  logic [31:0] cap [32];
  logic [31:0] ref_rows [32];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          last_done_cyc = 0;
  int          n_acc    = 0;
  int          n_xfer   = 0;
  int          ones     = 0;
  bit          in_glyph = 0;
  bit          first_pend = 0;
  bit          stall    = 0;
  bit          prev_stall = 0;
  logic [11:0] prev_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] font_a(input int r);
    case (r)
      0:       return 16'h07E0;
      1:       return 16'h0FF0;
      2:       return 16'h1C38;
      3:       return 16'h381C;
      6, 7:    return 16'h3FFC;
      14, 15:  return 16'h0000;
      default: return 16'h300C;
    endcase
  endfunction

  function automatic logic [31:0] expand(input logic [15:0] b);
    logic [31:0] o = '0;
    for (int i = 0; i < 16; i++) begin
      if (SC == 1) begin
        o[2*i]   = b[i];
        o[2*i+1] = b[i];
      end else begin
        o[i] = b[i];
      end
    end
    return o;
  endfunction

  // Scoreboard monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    exp_t e;
    int   eff, sr, xi, yi;
    cyc++;
    if (rst_n) begin
      check("busy", 32'(busy), 32'(in_glyph));
      check("char_ready", 32'(char_ready), 32'(!in_glyph));
      if (prev_stall)
        check("stall_hold", 32'({pix_valid, pix, pix_x, pix_y}), 32'(prev_out));
      if (first_pend && pix_valid) begin
        check("first_latency", 32'(cyc - acc_cyc), 32'd3);
        first_pend = 0;
      end
      if (pix_valid && pix_ready) begin
        e = (sb.size() != 0) ? sb.pop_front() : '1;
        check("pixel", 32'({rom_addr, pix_x, pix_y, pix, pix_last}), 32'(e));
        xi = int'(pix_x);
        yi = int'(pix_y);
        if (xi < NOUT && yi < NOUT) cap[yi][NOUT-1-xi] = pix;
        n_xfer++;
        ones += int'(pix);
        if (e.last) begin
          in_glyph      = 0;
          last_done_cyc = cyc;
          if (!stall) check("glyph_cycles", 32'(cyc - acc_cyc), 32'(GLYPH_CYC));
        end
      end
      if (char_valid && char_ready) begin
        eff = (int'(char_code) < 18) ? int'(char_code) : 16;
        for (int oy = 0; oy < NOUT; oy++) begin
          for (int ox = 0; ox < NOUT; ox++) begin
            sr     = oy >> SC;
            e.addr = 9'(eff * 16 + sr);
            e.x    = 5'(ox);
            e.y    = 5'(oy);
            e.pix  = rom_mem[9'(eff * 16 + sr)][15 - (ox >> SC)];
            e.last = (ox == NOUT - 1) && (oy == NOUT - 1);
            sb.push_back(e);
          end
        end
        foreach (cap[i]) cap[i] = '0;
        acc_cyc    = cyc;
        n_acc++;
        n_xfer     = 0;
        ones       = 0;
        in_glyph   = 1;
        first_pend = 1;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_out   = {pix_valid, pix, pix_x, pix_y};
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix"}, 32'(pix), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_pix_last"}, 32'(pix_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_char_ready"}, 32'(char_ready), 32'd1);
  endtask

  task automatic wait_accept(input int acc0, input int lim);
    int n = 0;
    while (n_acc == acc0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_timeout", 32'(n_acc != acc0), 32'd1);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (in_glyph && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_timeout", 32'(in_glyph), 32'd0);
  endtask

  task automatic run_glyph(input logic [4:0] code);
    int acc0 = n_acc;
    @(posedge clk);
    #1;
    char_code  = code;
    char_valid = 1'b1;
    wait_accept(acc0, 10);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    wait_done(GLYPH_CYC * 5);
  endtask

  initial begin
    int acc0, n;
    for (int a = 0; a < 512; a++) begin
      if (a >= 288)            rom_mem[a] = 16'hFFFF;
      else if (a / 16 == 0)    rom_mem[a] = font_a(a % 16);
      else if (a / 16 == 16)   rom_mem[a] = 16'h0000;
      else if (a / 16 == 17)   rom_mem[a] = (a % 16 == 5) ? 16'h03FC : 16'h0000;
      else                     rom_mem[a] = 16'((a / 16) * 16'h9E37 ^ (a % 16) * 16'h3C5B ^ 16'h5A5A);
    end
    rst_n      = 1'b1;
    char_code  = '0;
    char_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 'A'
    run_glyph(5'd0);
    check("a_xfers", 32'(n_xfer), 32'(NOUT * NOUT));
    check("a_row0", cap[0], expand(16'h07E0));
    check("a_row6", cap[6 << SC], expand(16'h3FFC));

    // flat
    run_glyph(5'd17);
    check("flat_xfers", 32'(n_xfer), 32'(NOUT * NOUT));
    check("flat_row5", cap[5 << SC], expand(16'h03FC));

    // out of range clamps to blank
    run_glyph(5'd25);
    check("oor_xfers", 32'(n_xfer), 32'(NOUT * NOUT));
    check("oor_ink", 32'(ones), 32'd0);

    // backpressure: same glyph with and without stalls
    run_glyph(5'd7);
    foreach (cap[i]) ref_rows[i] = cap[i];
    stall = 1;
    run_glyph(5'd7);
    stall = 0;
    check("bp_xfers", 32'(n_xfer), 32'(NOUT * NOUT));
    for (int r = 0; r < NOUT; r++) check($sformatf("bp_row%0d", r), cap[r], ref_rows[r]);

    // reset mid-glyph
    acc0 = n_acc;
    @(posedge clk);
    #1;
    char_code  = 5'd3;
    char_valid = 1'b1;
    wait_accept(acc0, 10);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    n = 0;
    while (!(pix_valid && pix_x == 5'd5 && pix_y == 5'd8) && n < GLYPH_CYC) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_point_timeout", 32'(pix_valid && pix_x == 5'd5 && pix_y == 5'd8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    sb.delete();
    in_glyph   = 0;
    first_pend = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_ready", 32'(char_ready), 32'd1);
    run_glyph(5'd1);
    check("post_rst_xfers", 32'(n_xfer), 32'(NOUT * NOUT));

    // char_valid held high across two glyphs
    acc0 = n_acc;
    @(posedge clk);
    #1;
    char_code  = 5'd2;
    char_valid = 1'b1;
    wait_accept(acc0, 10);
    @(posedge clk);
    #1;
    char_code = 5'd4;
    acc0 = n_acc;
    wait_accept(acc0, GLYPH_CYC * 2);
    check("back_to_back_gap", 32'(acc_cyc - last_done_cyc), 32'd1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    wait_done(GLYPH_CYC * 2);
    check("hold_xfers", 32'(n_xfer), 32'(NOUT * NOUT));
    check("sb_drained", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glyph_row_streamer.md
Name: glyph_row_streamer

Overview:
- Reader side of the 16x16 font ROM: accepts a glyph code, fetches its 16 rows over the ROM's synchronous address/data port, and serializes them into a pixel stream.
- Pixel stream uses a valid/ready handshake, so the downstream text/overlay blitter can write glyph pixels into the frame buffer at its own pace.
- The ROM's 1-cycle read latency is absorbed internally.

Parameters:
- NUM_GLYPHS, 18, count of valid glyph codes: 0-6 = A-G, 7-15 = digits 1-9, 16 = blank, 17 = flat.
- BLANK_CODE, 16, code substituted for any code >= NUM_GLYPHS.
- ROWS, 16, rows per glyph block; also the ROM address stride.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, reset, asynchronous, active-low.
- char_code_in, input, 5, glyph code to draw.
- char_valid_in, input, 1, code valid.
- char_ready_out, output, 1, high only in IDLE.
- rom_addr_out, output, 9, registered address to the font ROM.
- rom_data_in, input, 16, ROM row data, valid 1 cycle after the ROM samples the address.
- pix_out, output, 1, current pixel (1 = ink).
- pix_valid_out, output, 1, pixel valid.
- pix_ready_in, input, 1, downstream ready.
- pix_x_out, output, 5, pixel column.
- pix_y_out, output, 5, pixel row.
- pix_last_out, output, 1, high with the final pixel of the glyph.
- busy_out, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values (async assert, sync deassert): state IDLE, rom_addr_out = 0, pix_valid_out = 0, pix_out = 0, pix_x_out = 0, pix_y_out = 0, pix_last_out = 0, busy_out = 0, char_ready_out = 1.
- Code clamp: eff_code = (char_code_in < NUM_GLYPHS) ? char_code_in : BLANK_CODE. It is captured at accept.
- Address: rom_addr_out = eff_code*ROWS + row. Compute at 9 bits; no overflow for legal parameters.
- State machine:
  - IDLE: when char_valid_in && char_ready_out, capture eff_code, set row = 0, drive rom_addr_out, go to ADDR.
  - ADDR: ROM samples the address at the end of this cycle. Go to LATCH.
  - LATCH: rom_data_in is valid. Load it into a 16-bit shift register at the end of the cycle, set col = 0, go to SHIFT.
  - SHIFT: pix_valid_out = 1, pix_out = shreg[15] (MSB = leftmost column). On pix_valid_out && pix_ready_in, shift left and increment col. After col 15 is transferred:
    - if row < ROWS-1: row++, update rom_addr_out, go to ADDR;
    - else go to IDLE.
- Latency: the first pixel is valid 3 cycles after the accept edge. Each row costs 2 bubble cycles (ADDR, LATCH). With no backpressure, one glyph takes 16*(16+2) = 288 cycles.
- Handshake rules:
  - In SHIFT, pix_out, pix_x_out and pix_y_out stay stable while pix_valid_out && !pix_ready_in.
  - pix_valid_out never drops in SHIFT without a transfer.
- pix_last_out = pix_valid_out && last row && last column.
- pix_x_out / pix_y_out carry the column and row of the pixel currently presented.
- Simultaneous events:
  - char_valid_in is ignored outside IDLE.
  - On the final pixel transfer, the next state is IDLE, so char_ready_out rises the following cycle. There is no same-cycle accept.
- Reset mid-glyph aborts immediately. Outputs return to reset values, no further pixels are emitted, and no partial-row completion occurs.
- rom_addr_out holds its last value in IDLE.

Optional Feature:
- Macro: GLYPH_SCALE2_EN.
- Defined: glyph is output at 32x32.
  - Each source row is fetched twice, for output rows 2r and 2r+1. Each source bit is presented for 2 consecutive transfers.
  - pix_x_out and pix_y_out range 0-31.
  - pix_last_out fires at (31,31).
  - Row bubble is still 2 cycles per output row.
- Undefined: 16x16 behaviour as above. pix_x_out and pix_y_out bits [4] are tied to 0.

Test Plan:
- Code 0 ('A'), pix_ready_in = 1:
  - rom_addr_out steps through 0..15;
  - row-0 pixels read 0000011111100000;
  - the row-6 pattern is correct;
  - exactly 256 transfers occur, pix_last_out is high only at (15,15), and the glyph completes in 288 cycles.
- Code 17 (flat): addresses 272..287; row 5 outputs 0000001111111100.
- Code 25 (out of range): addresses 256..271 are issued, all 256 pixels are 0, and pix_last_out fires.
- Backpressure: toggle pix_ready_in randomly (about 50%) on code 7 ('1'):
  - outputs stay stable while stalled;
  - the pixel sequence matches the no-stall run bit-for-bit.
- Assert rst_n_in low at row 8, col 5 of code 3:
  - all outputs reach reset values asynchronously;
  - after release, char_ready_out = 1 and a new code 1 streams correctly from row 0.
- Hold char_valid_in high continuously with codes 2 then 4:
  - second accept occurs exactly 1 cycle after glyph 1's last transfer;
  - no code is accepted while busy_out = 1.
  - With GLYPH_SCALE2_EN defined, also confirm 1024 transfers and pix_last_out at (31,31).
